// File: rtl/dm_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core (port 0)
// and the host loader (port 1).
package dm_arbiter_pkg;

  localparam int unsigned DM_ADDR_W = 16;
  localparam int unsigned DM_DATA_W = 8;
  localparam int unsigned DM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Saturating burst-count increment
  function automatic logic [DM_CNT_W-1:0] burst_inc(input logic [DM_CNT_W-1:0] cnt,
                                                    input logic [DM_CNT_W-1:0] max);
    return (cnt >= max) ? max : cnt + DM_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W
);

  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: alternating tie-break from IDLE, bounded bursts
// per owner, single-cycle grant with one-cycle read return.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DM_ADDR_W,
  parameter int unsigned DATA_W    = DM_DATA_W,
  parameter int unsigned MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  dm_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = DM_CNT_W;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  state_e           state_q;
  state_e           state_d;
  logic             last_q;   // 1 = port 1 was served most recently
  logic             last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rv0_q;
  logic             rv1_q;
  logic             pick0;
  logic             pick1;
  logic             gnt0;
  logic             gnt1;
  logic             at_max;

  assign at_max = (cnt_q >= BURST_MAX);

  // State, pointer, burst counter and read-return flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= gnt0 & ~bus.wr0;
      rv1_q   <= gnt1 & ~bus.wr1;
    end
  end

  // Grant decision and next state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pick0   = 1'b0;
    pick1   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          pick0 = bus.req0 & (~bus.req1 | last_q);
          pick1 = bus.req1 & ~pick0;
        end
        OWN0: begin
          pick0 = bus.req0 & (~at_max | ~bus.req1);
          pick1 = bus.req1 & ~pick0;
        end
        OWN1: begin
          pick1 = bus.req1 & (~at_max | ~bus.req0);
          pick0 = bus.req0 & ~pick1;
        end
        default: begin
          pick0 = 1'b0;
          pick1 = 1'b0;
        end
      endcase

      if (pick0) begin
        gnt0    = 1'b1;
        last_d  = 1'b0;
        state_d = OWN0;
        cnt_d   = (state_q == OWN0) ? burst_inc(cnt_q, BURST_MAX) : CNT_W'(1);
      end else if (pick1) begin
        gnt1    = 1'b1;
        last_d  = 1'b1;
        state_d = OWN1;
        cnt_d   = (state_q == OWN1) ? burst_inc(cnt_q, BURST_MAX) : CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Memory port follows the granted requester, quiet otherwise
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_wdata = DATA_W'(0);
    if (gnt0) begin
      bus.mem_wr    = bus.wr0;
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_wr    = bus.wr1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  // A read granted just before reset must not surface while reset is high
  assign bus.rvalid0 = rv0_q & ~rst;
  assign bus.rvalid1 = rv1_q & ~rst;
  assign bus.rdata0  = bus.mem_rdata;
  assign bus.rdata1  = bus.mem_rdata;

endmodule
